// File: rtl/seq_divider_if.sv
// seq_divider_if
// Groups the request/response signals of the sequential divider.
//   start, signed_op, dividend, divisor       : request, driven by the master
//   busy, done, quotient, remainder, div_by_zero : response, driven by the divider
// Modports:
//   master : the client issuing divisions
//   slave  : the divider itself
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider
// Multi-cycle restoring integer divider, one shift-subtract step per clock.
// One division in flight at a time. Quotient truncates toward zero and the
// remainder takes the sign of the dividend. Latency from accepted start to
// done is WIDTH+1 clocks.
// Parameters:
//   WIDTH     : operand/result width (>= 2)
//   SIGNED_EN : 1 = bus.signed_op honoured, 0 = always unsigned
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_divider_if slave modport (request in, registered results out)
module seq_divider #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_mag_q;
  logic [CW-1:0]    cnt_q;
  logic             dvd_neg_q;
  logic             quo_neg_q;
  logic             dbz_q;

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_out_q;

  logic             is_signed;
  logic             dvd_in_neg;
  logic             dvs_in_neg;
  logic [WIDTH-1:0] dvd_mag_in;
  logic [WIDTH-1:0] dvs_mag_in;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = bus.start ? CALC : IDLE;
      CALC:       if (cnt_q == CW'(1)) state_d = FIX;
      FIX:        state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Operand magnitudes; unary minus maps the most-negative value onto
  // 2^(WIDTH-1), which the unsigned core handles directly.
  always_comb begin
    is_signed  = SIGNED_EN && bus.signed_op;
    dvd_in_neg = is_signed && bus.dividend[WIDTH-1];
    dvs_in_neg = is_signed && bus.divisor[WIDTH-1];
    dvd_mag_in = dvd_in_neg ? -bus.dividend : bus.dividend;
    dvs_mag_in = dvs_in_neg ? -bus.divisor  : bus.divisor;
  end

  // The partial remainder is always below the divisor, so the shifted value
  // minus the divisor fits in WIDTH+1 bits and its MSB is a true sign bit.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_mag_q};
    trial_ok = ~trial[WIDTH];
  end

  // quo_q starts out holding the dividend magnitude; its bits shift out into
  // the partial remainder while quotient bits shift in from the bottom.
  // A zero divisor makes every trial succeed, leaving the dividend magnitude
  // as remainder, so after sign fix-up the remainder is the original dividend
  // and only the quotient needs overriding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_mag_q   <= '0;
      cnt_q       <= '0;
      dvd_neg_q   <= 1'b0;
      quo_neg_q   <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_out_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            dvd_neg_q <= dvd_in_neg;
            quo_neg_q <= dvd_in_neg ^ dvs_in_neg;
            dbz_q     <= (bus.divisor == '0);
            dvs_mag_q <= dvs_mag_in;
            quo_q     <= dvd_mag_in;
            rem_q     <= '0;
            cnt_q     <= CW'(WIDTH);
          end
        end
        CALC: begin
          rem_q <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], trial_ok};
          cnt_q <= cnt_q - CW'(1);
        end
        FIX: begin
          if (dbz_q) begin
            quotient_q <= '1;
          end else begin
            quotient_q <= quo_neg_q ? -quo_q : quo_q;
          end
          remainder_q <= dvd_neg_q ? -rem_q : rem_q;
          dbz_out_q   <= dbz_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy        = (state_q == CALC) || (state_q == FIX);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
// Scoreboard bench for seq_divider: a WIDTH=8 signed-capable instance and a
// WIDTH=16 unsigned-only instance. Stimulus pushes hand-computed results into
// per-instance queues; monitors pop and compare whenever done is seen.
module tb_seq_divider;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          startCyc;
  } exp_t;

  typedef struct {
    logic        signedOp;
    logic [15:0] dvd;
    logic [15:0] dvs;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } vec_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   testsRun = 0;
  int   failures = 0;
  int   doneCount8 = 0;
  int   doneCount16 = 0;
  int   lastDone8 = 0;

  exp_t exp8[$];
  exp_t exp16[$];

  seq_divider_if #(.WIDTH(8))  bus8 ();
  seq_divider_if #(.WIDTH(16)) bus16 ();

  seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  seq_divider #(.WIDTH(16), .SIGNED_EN(1'b0)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Drives a request at the current (negedge) time, records the expected
  // result with the sampling edge number, then drops start at the next negedge.
  task automatic applyStimulus(input int unit, input logic signedOp,
                               input logic [15:0] dvd, input logic [15:0] dvs,
                               input logic [15:0] expQ, input logic [15:0] expR,
                               input logic expDbz);
    exp_t e;
    if (unit == 8) begin
      bus8.signed_op = signedOp;
      bus8.dividend  = dvd[7:0];
      bus8.divisor   = dvs[7:0];
      bus8.start     = 1'b1;
    end else begin
      bus16.signed_op = signedOp;
      bus16.dividend  = dvd;
      bus16.divisor   = dvs;
      bus16.start     = 1'b1;
    end
    @(posedge clk);
    #1;
    e.q = expQ;
    e.r = expR;
    e.dbz = expDbz;
    e.startCyc = cyc;
    if (unit == 8) exp8.push_back(e);
    else exp16.push_back(e);
    @(negedge clk);
    bus8.start  = 1'b0;
    bus16.start = 1'b0;
  endtask

  task automatic waitDone(input int unit, output int busyCnt);
    bit seen;
    busyCnt = 0;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      if ((unit == 8) ? bus8.done : bus16.done) begin
        seen = 1'b1;
      end else begin
        if ((unit == 8) ? bus8.busy : bus16.busy) busyCnt++;
        @(negedge clk);
      end
    end
    if (!seen) begin
      testsRun++;
      failures++;
      $display("[TB] FAIL done_timeout unit=%0d actual=no done required=done within 60 cycles", unit);
    end
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && bus8.done) begin
        checkOutput("busy_with_done8", {31'b0, bus8.busy}, 32'd0);
        if (exp8.size() == 0) begin
          testsRun++;
          failures++;
          $display("[TB] FAIL unexpected_done8 actual=done required=no pending operation");
        end else begin
          e = exp8.pop_front();
          checkOutput("quotient8", {24'b0, bus8.quotient}, {16'b0, e.q});
          checkOutput("remainder8", {24'b0, bus8.remainder}, {16'b0, e.r});
          checkOutput("div_by_zero8", {31'b0, bus8.div_by_zero}, {31'b0, e.dbz});
          checkOutput("latency8", cyc - e.startCyc, 32'd9);
        end
        doneCount8++;
        lastDone8 = cyc;
      end
    end
  end

  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && bus16.done) begin
        checkOutput("busy_with_done16", {31'b0, bus16.busy}, 32'd0);
        if (exp16.size() == 0) begin
          testsRun++;
          failures++;
          $display("[TB] FAIL unexpected_done16 actual=done required=no pending operation");
        end else begin
          e = exp16.pop_front();
          checkOutput("quotient16", {16'b0, bus16.quotient}, {16'b0, e.q});
          checkOutput("remainder16", {16'b0, bus16.remainder}, {16'b0, e.r});
          checkOutput("div_by_zero16", {31'b0, bus16.div_by_zero}, {31'b0, e.dbz});
          checkOutput("latency16", cyc - e.startCyc, 32'd17);
        end
        doneCount16++;
      end
    end
  end

  vec_t vecs8[12] = '{
    '{1'b0, 16'd200,  16'd7,    16'd28,   16'd4,    1'b0},
    '{1'b1, 16'h00F9, 16'h0002, 16'h00FD, 16'h00FF, 1'b0},
    '{1'b1, 16'h0007, 16'h00FE, 16'h00FD, 16'h0001, 1'b0},
    '{1'b1, 16'h0080, 16'h00FF, 16'h0080, 16'h0000, 1'b0},
    '{1'b0, 16'h000D, 16'h0000, 16'h00FF, 16'h000D, 1'b1},
    '{1'b1, 16'h000D, 16'h0000, 16'h00FF, 16'h000D, 1'b1},
    '{1'b1, 16'h00F3, 16'h0000, 16'h00FF, 16'h00F3, 1'b1},
    '{1'b0, 16'd100,  16'd10,   16'd10,   16'd0,    1'b0},
    '{1'b1, 16'h0080, 16'h0001, 16'h0080, 16'h0000, 1'b0},
    '{1'b1, 16'h0081, 16'h0004, 16'h00E1, 16'h00FD, 1'b0},
    '{1'b0, 16'd5,    16'd9,    16'd0,    16'd5,    1'b0},
    '{1'b0, 16'h00FF, 16'h00FF, 16'h0001, 16'h0000, 1'b0}
  };

  initial begin
    int busyCnt;
    int d0;
    int firstDone;

    rst_n = 1'b0;
    bus8.start = 1'b0;   bus8.signed_op = 1'b0;  bus8.dividend = '0;  bus8.divisor = '0;
    bus16.start = 1'b0;  bus16.signed_op = 1'b0; bus16.dividend = '0; bus16.divisor = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'b0, bus8.busy}, 32'd0);
    checkOutput("reset_done", {31'b0, bus8.done}, 32'd0);
    checkOutput("reset_quotient", {24'b0, bus8.quotient}, 32'd0);
    checkOutput("reset_remainder", {24'b0, bus8.remainder}, 32'd0);
    checkOutput("reset_dbz", {31'b0, bus8.div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, each started from idle.
    foreach (vecs8[i]) begin
      applyStimulus(8, vecs8[i].signedOp, vecs8[i].dvd, vecs8[i].dvs,
                    vecs8[i].q, vecs8[i].r, vecs8[i].dbz);
      waitDone(8, busyCnt);
      checkOutput("busy_cycles8", busyCnt, 32'd9);
      repeat (2) @(negedge clk);
    end

    // Start pulsed mid-calculation with other operands is ignored.
    d0 = doneCount8;
    applyStimulus(8, 1'b0, 16'd50, 16'd5, 16'd10, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    bus8.start = 1'b1;
    bus8.dividend = 8'd9;
    bus8.divisor = 8'd3;
    @(negedge clk);
    bus8.start = 1'b0;
    waitDone(8, busyCnt);
    repeat (15) @(negedge clk);
    checkOutput("ignored_start_one_done", doneCount8 - d0, 32'd1);

    // Back-to-back: second start issued in the done cycle.
    applyStimulus(8, 1'b0, 16'd200, 16'd7, 16'd28, 16'd4, 1'b0);
    waitDone(8, busyCnt);
    firstDone = cyc;
    applyStimulus(8, 1'b0, 16'd255, 16'd16, 16'd15, 16'd15, 1'b0);
    checkOutput("held_busy_rise", {31'b0, bus8.busy}, 32'd1);
    checkOutput("held_quotient", {24'b0, bus8.quotient}, 32'd28);
    repeat (4) @(negedge clk);
    checkOutput("held_remainder", {24'b0, bus8.remainder}, 32'd4);
    waitDone(8, busyCnt);
    checkOutput("b2b_spacing", cyc - firstDone, 32'd10);
    repeat (2) @(negedge clk);

    // Reset in the middle of the fourth iteration.
    applyStimulus(8, 1'b0, 16'd77, 16'd3, 16'd25, 16'd2, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", {31'b0, bus8.busy}, 32'd0);
    checkOutput("midreset_done", {31'b0, bus8.done}, 32'd0);
    checkOutput("midreset_quotient", {24'b0, bus8.quotient}, 32'd0);
    checkOutput("midreset_remainder", {24'b0, bus8.remainder}, 32'd0);
    checkOutput("midreset_dbz", {31'b0, bus8.div_by_zero}, 32'd0);
    exp8.delete();
    d0 = doneCount8;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    checkOutput("midreset_no_done", doneCount8 - d0, 32'd0);
    applyStimulus(8, 1'b0, 16'd255, 16'd16, 16'd15, 16'd15, 1'b0);
    waitDone(8, busyCnt);
    checkOutput("busy_cycles_after_reset", busyCnt, 32'd9);
    repeat (2) @(negedge clk);

    // 16-bit instance with signed support disabled.
    applyStimulus(16, 1'b1, 16'hFFFF, 16'h0003, 16'h5555, 16'h0000, 1'b0);
    waitDone(16, busyCnt);
    checkOutput("busy_cycles16", busyCnt, 32'd17);
    repeat (2) @(negedge clk);
    applyStimulus(16, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0);
    waitDone(16, busyCnt);
    repeat (2) @(negedge clk);
    applyStimulus(16, 1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1);
    waitDone(16, busyCnt);
    repeat (3) @(negedge clk);

    checkOutput("pending8", exp8.size(), 32'd0);
    checkOutput("pending16", exp16.size(), 32'd0);
    checkOutput("done_count16", doneCount16, 32'd3);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
